// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and fetches one instruction at a time over a req/ack port.
// Optional feature macro: IF_MISALIGN_CHECK_EN (aligns redirect targets, flags misaligned ones).
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pause,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr,
  output logic        o_if_misalign
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic [31:0] pend_q;
  logic [31:0] pend_next;
  logic [31:0] instr_q;
  logic [31:0] instr_next;
  logic [31:0] tgt;

`ifdef IF_MISALIGN_CHECK_EN
  logic misalign_q;
  logic misalign_next;

  assign tgt           = {i_redirect_pc[31:2], 2'b00};
  assign misalign_next = i_redirect_valid && (i_redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_next;
    end
  end

  assign o_if_misalign = misalign_q;
`else
  assign tgt           = i_redirect_pc;
  assign o_if_misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= RESET_PC;
      instr_q <= 32'h0;
    end else begin
      state   <= state_next;
      pc_q    <= pc_next;
      pend_q  <= pend_next;
      instr_q <= instr_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    pend_next  = pend_q;
    instr_next = instr_q;
    unique case (state)
      IDLE: begin
        state_next = FETCH;
        if (i_redirect_valid) begin
          pc_next = tgt;
        end
      end
      FETCH: begin
        if (i_redirect_valid) begin
          // Without ack the address must stay put, so the target waits in pend_q.
          if (i_imem_ack) begin
            pc_next = tgt;
          end else begin
            pend_next  = tgt;
            state_next = DROP;
          end
        end else if (i_imem_ack) begin
          instr_next = i_imem_rdata;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (i_redirect_valid) begin
          pc_next    = tgt;
          state_next = FETCH;
        end else if (!pause) begin
          pc_next    = pc_q + 32'd4;
          state_next = FETCH;
        end
      end
      DROP: begin
        if (i_redirect_valid) begin
          pend_next = tgt;
        end
        if (i_imem_ack) begin
          pc_next    = i_redirect_valid ? tgt : pend_q;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_imem_req  = (state == FETCH) || (state == DROP);
  assign o_imem_addr = pc_q;
  assign o_if_valid  = (state == HOLD);
  assign o_if_pc     = pc_q;
  assign o_if_instr  = (state == HOLD) ? instr_q : 32'h0;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed and randomized bench for if_fetch_stage; memory words are a hash of their address.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pause;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        o_if_valid;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_instr;
  logic        o_if_misalign;

  int checks = 0;
  int errors = 0;
  int wait_cnt = 0;
  int mem_wait = 0;
  bit rand_wait = 1'b0;

  if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .pause            (pause),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_imem_req       (o_imem_req),
    .o_imem_addr      (o_imem_addr),
    .i_imem_ack       (i_imem_ack),
    .i_imem_rdata     (i_imem_rdata),
    .o_if_valid       (o_if_valid),
    .o_if_pc          (o_if_pc),
    .o_if_instr       (o_if_instr),
    .o_if_misalign    (o_if_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then answer the request that is visible for the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (resetn && o_imem_req) begin
      if (wait_cnt == 0 && rand_wait) mem_wait = $urandom_range(0, 3);
      if (wait_cnt >= mem_wait) begin
        i_imem_ack   = 1'b1;
        i_imem_rdata = memf(o_imem_addr);
        wait_cnt     = 0;
      end else begin
        i_imem_ack   = 1'b0;
        i_imem_rdata = $urandom;
        wait_cnt++;
      end
    end else begin
      i_imem_ack   = 1'b0;
      i_imem_rdata = $urandom;
      wait_cnt     = 0;
    end
  endtask

  task automatic wait_hold(input string tag);
    int n = 0;
    while (!o_if_valid && n < 20) begin
      tick();
      n++;
    end
    chk1({tag, "_valid"}, o_if_valid, 1'b1);
  endtask

  task automatic present(input string tag, input logic [31:0] pc);
    chk1({tag, "_valid"}, o_if_valid, 1'b1);
    chk({tag, "_pc"}, o_if_pc, pc);
    chk({tag, "_instr"}, o_if_instr, memf(pc));
    chk1({tag, "_noreq"}, o_imem_req, 1'b0);
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] t;
    logic [31:0] t_m;
    logic        r;
    logic        exp_mis;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;
    int          presented;
    int          n;

    resetn = 1'b0; pause = 1'b0; i_redirect_valid = 1'b0; i_redirect_pc = 32'h0;
    i_imem_ack = 1'b0; i_imem_rdata = 32'h0;
    tick(); tick();
    chk1("rst_req", o_imem_req, 1'b0);
    chk("rst_addr", o_imem_addr, RESET_PC);
    chk1("rst_valid", o_if_valid, 1'b0);
    chk("rst_instr", o_if_instr, 32'h0);
    chk("rst_pc", o_if_pc, RESET_PC);
    chk1("rst_misalign", o_if_misalign, 1'b0);

    // Zero-wait streaming from reset
    resetn = 1'b1;
    chk1("idle_req", o_imem_req, 1'b0);
    tick();
    chk1("first_req", o_imem_req, 1'b1);
    chk("first_addr", o_imem_addr, 32'h0);
    tick(); present("hold0", 32'h0);
    tick(); chk("req4_addr", o_imem_addr, 32'h4);
    tick(); present("hold4", 32'h4);
    tick(); chk("req8_addr", o_imem_addr, 32'h8);
    tick(); present("hold8", 32'h8);

    // Pause for five cycles
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      present("pause", 32'h8);
    end
    pause = 1'b0;
    tick();
    chk1("unpause_req", o_imem_req, 1'b1);
    chk("unpause_addr", o_imem_addr, 32'hC);
    tick(); present("holdC", 32'hC);

    // Redirect during a 3-wait fetch
    mem_wait = 3;
    tick();
    chk("slow_addr", o_imem_addr, 32'h10);
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h100;
    tick();
    i_redirect_valid = 1'b0;
    n = 0;
    while (!i_imem_ack && n < 10) begin
      chk("drop_addr", o_imem_addr, 32'h10);
      tick();
      n++;
    end
    chk("drop_ack_addr", o_imem_addr, 32'h10);
    tick();
    chk1("after_drop_req", o_imem_req, 1'b1);
    chk("after_drop_addr", o_imem_addr, 32'h100);
    wait_hold("w100");
    present("hold100", 32'h100);

    // Two redirects while dropping
    tick();
    chk("f104_addr", o_imem_addr, 32'h104);
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h200;
    tick();
    i_redirect_pc = 32'h300;
    tick();
    i_redirect_valid = 1'b0;
    n = 0;
    while (o_imem_addr == 32'h104 && n < 10) begin
      tick();
      n++;
    end
    chk1("dbl_req", o_imem_req, 1'b1);
    chk("dbl_addr", o_imem_addr, 32'h300);
    wait_hold("w300");
    present("hold300", 32'h300);

    // Redirect and pause together in HOLD
    mem_wait = 0;
    pause = 1'b1; i_redirect_valid = 1'b1; i_redirect_pc = 32'h400;
    tick();
    pause = 1'b0; i_redirect_valid = 1'b0;
    chk1("rp_req", o_imem_req, 1'b1);
    chk("rp_addr", o_imem_addr, 32'h400);
    tick(); present("hold400", 32'h400);

    // PC wrap-around
    i_redirect_valid = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
    tick();
    i_redirect_valid = 1'b0;
    tick(); present("holdFFC", 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr", o_imem_addr, 32'h0);
    tick(); present("hold_wrap", 32'h0);

    // Misaligned redirect target
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h102;
    tick();
    i_redirect_valid = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
    chk("mis_addr", o_imem_addr, 32'h100);
    chk1("mis_pulse", o_if_misalign, 1'b1);
    tick();
    chk1("mis_pulse_end", o_if_misalign, 1'b0);
    present("hold_mis", 32'h100);
    exp_pc = 32'h100;
`else
    chk("mis_addr", o_imem_addr, 32'h102);
    chk1("mis_tied", o_if_misalign, 1'b0);
    tick();
    chk1("mis_tied2", o_if_misalign, 1'b0);
    present("hold_mis", 32'h102);
    exp_pc = 32'h102;
`endif

    // Randomized run against the scoreboard: the next presented PC is the
    // latest redirect target, or the previous PC plus 4 once consumed.
    rand_wait = 1'b1;
    presented = 0;
    for (int i = 0; i < 1500; i++) begin
      pause = ($urandom_range(0, 2) == 0);
      r     = ($urandom_range(0, 7) == 0);
      t     = $urandom;
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
`ifdef IF_MISALIGN_CHECK_EN
      t_m     = {t[31:2], 2'b00};
      exp_mis = r && (t[1:0] != 2'b00);
`else
      t       = {t[31:2], 2'b00};
      t_m     = t;
      exp_mis = 1'b0;
`endif
      i_redirect_valid = r;
      i_redirect_pc    = t;
      if (r) exp_pc = t_m;
      else if (o_if_valid && !pause) exp_pc = exp_pc + 32'd4;
      prev_req  = o_imem_req;
      prev_ack  = i_imem_ack;
      prev_addr = o_imem_addr;
      tick();
      if (o_if_valid) begin
        presented++;
        chk("rnd_pc", o_if_pc, exp_pc);
        chk("rnd_instr", o_if_instr, memf(exp_pc));
        chk1("rnd_noreq", o_imem_req, 1'b0);
      end else begin
        chk("rnd_instr_zero", o_if_instr, 32'h0);
      end
      if (prev_req && !prev_ack) begin
        chk1("rnd_req_held", o_imem_req, 1'b1);
        chk("rnd_addr_stable", o_imem_addr, prev_addr);
      end
      chk1("rnd_misalign", o_if_misalign, exp_mis);
    end
    i_redirect_valid = 1'b0;
    pause = 1'b0;
    chk1("rnd_progress", presented >= 100, 1'b1);

    // Asynchronous reset in the middle of an outstanding request
    mem_wait = 3;
    rand_wait = 1'b0;
    n = 0;
    while (!(o_imem_req && !i_imem_ack) && n < 20) begin
      tick();
      n++;
    end
    chk1("mid_req_seen", o_imem_req, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    chk1("async_req", o_imem_req, 1'b0);
    chk("async_addr", o_imem_addr, RESET_PC);
    chk1("async_valid", o_if_valid, 1'b0);
    chk("async_pc", o_if_pc, RESET_PC);
    chk("async_instr", o_if_instr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the pipelined CPU. Owns the program counter and issues single-beat requests to instruction memory over a req/ack handshake. Presents one fetched instruction at a time, with its PC, to the IF/ID pipeline register. Honours hazard-unit pause and branch/jump redirects, including redirects that arrive while a memory request is outstanding.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC fetched first after reset.
- `clk`  in  1  clock; one clock, all state on rising edge.
- `resetn`  in  1  reset; asynchronous and active-low.
- `pause`  in  1  hazard-unit stall; the held instruction is not consumed.
- `i_redirect_valid`  in  1  branch/jump taken this cycle.
- `i_redirect_pc`  in  32  redirect target.
- `o_imem_req`  out  1  fetch request.
- `o_imem_addr`  out  32  fetch address; stable while `o_imem_req` is high until ack.
- `i_imem_ack`  in  1  request accepted; data valid in the same cycle.
- `i_imem_rdata`  in  32  instruction word.
- `o_if_valid`  out  1  `o_if_instr` holds a real instruction.
- `o_if_pc`  out  32  PC of the presented instruction (`pc_q`).
- `o_if_instr`  out  32  instruction; 32'h0 when `o_if_valid` is 0.
- `o_if_misalign`  out  1  misaligned-redirect pulse (see Configuration).

## Operation
- Registers:
  - `pc_q`: address of the current fetch.
  - `pend_q`: redirect target saved while a fetch is being dropped.
  - `instr_q`: captured instruction.
  - `state`: IDLE, FETCH, HOLD or DROP.
- Redirect has priority over pause and over normal sequencing. When two redirects conflict, the later one wins.
- **IDLE** (reset state): no request. Goes to FETCH on the next cycle.
- **FETCH**: `o_imem_req`=1, `o_imem_addr`=`pc_q`.
  - Redirect with ack: `pc_q`<=target, stay in FETCH. The returned data is discarded.
  - Redirect without ack: `pend_q`<=target, go to DROP. `pc_q` is unchanged, so the address stays stable.
  - Ack with no redirect: `instr_q`<=`i_imem_rdata`, go to HOLD.
- **HOLD**: `o_imem_req`=0, `o_if_valid`=1, `o_if_instr`=`instr_q`.
  - Redirect: `pc_q`<=target, go to FETCH.
  - Else if `pause`=0: the instruction is consumed; `pc_q`<=`pc_q`+4, go to FETCH.
  - Else: stay in HOLD with all values held.
- **DROP**: `o_imem_req`=1, `o_imem_addr`=`pc_q` (the old address).
  - Redirect: `pend_q`<=new target.
  - Ack: the data is discarded; `pc_q`<=(redirect this cycle ? new target : `pend_q`), go to FETCH.
- PC arithmetic: unsigned 32-bit addition modulo 2^32. 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Outputs during reset: `o_imem_req`=0, `o_imem_addr`=`RESET_PC`, `o_if_valid`=0, `o_if_instr`=0, `o_if_pc`=`RESET_PC`, `o_if_misalign`=0.
- Reset asserted mid-request: all state clears immediately. The abandoned memory transaction is the memory's responsibility.

## Timing
- All outputs are decoded from registered state; there is no combinational path from `pause` or the redirect inputs to any output.
- Earliest ack in the first FETCH cycle gives: FETCH (cycle n) -> HOLD (n+1) -> FETCH (n+2).
- Peak throughput is 1 instruction per 2 cycles. Each extra memory wait cycle adds 1 cycle.
- Redirect-to-first-request latency: 1 cycle from FETCH/HOLD; from DROP, 1 cycle after the outstanding ack.
- A held instruction stays constant for as long as `pause`=1.
- After reset release: IDLE for 1 cycle, then the request for `RESET_PC`.

## Configuration
- Macro: `IF_MISALIGN_CHECK_EN`.
- Defined:
  - Every accepted redirect target has bits [1:0] forced to 0 before use.
  - If the original bits [1:0] were nonzero, `o_if_misalign` pulses high for exactly the cycle after the redirect.
- Undefined:
  - The target is used unmodified.
  - `o_if_misalign` is tied to 0.

## Test plan
- Reset then release with zero-wait memory (ack on every request) and `RESET_PC`=0:
  - First request is at cycle 1 after release.
  - HOLD presents pc 0x0, 0x4, 0x8 on alternate cycles.
- `pause` high for 5 cycles in HOLD:
  - `o_if_valid`, `o_if_pc` and `o_if_instr` stay constant.
  - No request is issued.
  - After release, the next address is pc+4.
- Memory with 3 wait cycles, redirect to 0x100 in the first FETCH cycle:
  - Address stays at the old pc until ack; that data is dropped.
  - The next request is 0x100.
- Two redirects (0x200, then 0x300) while in DROP: the next fetch is 0x300.
- Redirect and `pause` together in HOLD: the redirect wins and the next request is the target.
- `pc_q`=32'hFFFF_FFFC consumed: next address is 0x0.
- With `IF_MISALIGN_CHECK_EN`, redirect to 0x102:
  - Fetch address is 0x100.
  - `o_if_misalign` is high for 1 cycle.
